// File: rtl/al4s3b_wb_pkg.sv
// Shared definitions for the AL4S3B Wishbone initiator and the register slaves it talks to.
package al4s3b_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } wb_state_e;

  localparam int BYTE_STB_W = 4;

  // Read data returned on a timeout abort. The QL reserved block answers
  // with the same value so both ends of the bus agree.
  localparam logic [31:0] ERR_RD_VALUE_DEF     = 32'hDEF_FAB_AC;
  localparam logic [31:0] QL_DEFAULT_REG_VALUE = ERR_RD_VALUE_DEF;

endpackage

// File: rtl/al4s3b_wb_master_if.sv
// Command/response handshake and Wishbone bus bundle for the AL4S3B initiator.
// cmd and rsp are strict valid/ready: a transfer happens on any edge where valid&ready are both high.
interface al4s3b_wb_master_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  logic                                  cmd_valid_i;
  logic                                  cmd_ready_o;
  logic                                  cmd_we_i;
  logic [ADDRWIDTH-1:0]                  cmd_adr_i;
  logic [DATAWIDTH-1:0]                  cmd_dat_i;
  logic [al4s3b_wb_pkg::BYTE_STB_W-1:0]  cmd_sel_i;

  logic                                  rsp_valid_o;
  logic                                  rsp_ready_i;
  logic [DATAWIDTH-1:0]                  rsp_dat_o;
  logic                                  rsp_err_o;

  logic [ADDRWIDTH-1:0]                  WBm_ADR_o;
  logic                                  WBm_CYC_o;
  logic                                  WBm_STB_o;
  logic                                  WBm_WE_o;
  logic [al4s3b_wb_pkg::BYTE_STB_W-1:0]  WBm_BYTE_STB_o;
  logic [DATAWIDTH-1:0]                  WBm_DAT_o;
  logic [DATAWIDTH-1:0]                  WBm_DAT_i;
  logic                                  WBm_ACK_i;

  al4s3b_wb_pkg::wb_state_e              state_dbg;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i, WBm_DAT_i, WBm_ACK_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_BYTE_STB_o, WBm_DAT_o,
    output state_dbg
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i, WBm_DAT_i, WBm_ACK_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_BYTE_STB_o, WBm_DAT_o,
    input  state_dbg
  );
endinterface

// File: rtl/al4s3b_wb_timeout_cntr.sv
// Loadable down-counter with zero detect; bounds how long STB waits for ACK.
module al4s3b_wb_timeout_cntr #(
  parameter int WIDTH = 5
) (
  input  logic             WBs_CLK_i,
  input  logic             WBs_RST_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/al4s3b_wb_master.sv
// Single-outstanding Wishbone initiator: one command in, one classic CYC/STB cycle,
// one response out, with a timeout that turns a missing ACK into an error response.
module al4s3b_wb_master
  import al4s3b_wb_pkg::*;
#(
  parameter int                    ADDRWIDTH     = 17,
  parameter int                    DATAWIDTH     = 32,
  parameter int                    TO_CNTR_WIDTH = 5,
  parameter int                    TO_CYCLES     = 16,
  parameter logic [DATAWIDTH-1:0]  ERR_RD_VALUE  = ERR_RD_VALUE_DEF
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  al4s3b_wb_master_if.master   bus,
  output logic [7:0]           to_count_o
);
  localparam logic [TO_CNTR_WIDTH-1:0] TO_LOAD = TO_CNTR_WIDTH'(TO_CYCLES - 1);

  wb_state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0]    adr_q, adr_d;
  logic [DATAWIDTH-1:0]    dat_q, dat_d;
  logic [BYTE_STB_W-1:0]   sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    cyc_q, cyc_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]    rsp_dat_q, rsp_dat_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [7:0]              to_count_q, to_count_d;
  logic                    cmd_ready;
  logic                    cnt_load, cnt_dec, cnt_zero;

  al4s3b_wb_timeout_cntr #(.WIDTH(TO_CNTR_WIDTH)) u_to_cntr (
    .WBs_CLK_i  (WBs_CLK_i),
    .WBs_RST_i  (WBs_RST_i),
    .load_i     (cnt_load),
    .load_val_i (TO_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    to_count_d  = to_count_q;
    cmd_ready   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          adr_d    = bus.cmd_adr_i;
          dat_d    = bus.cmd_dat_i;
          sel_d    = bus.cmd_sel_i;
          we_d     = bus.cmd_we_i;
          cyc_d    = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // ACK is checked before the counter so an ACK on the last cycle still succeeds.
        if (bus.WBm_ACK_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : bus.WBm_DAT_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_zero) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : ERR_RD_VALUE;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (to_count_q != 8'hFF) to_count_d = to_count_q + 8'd1;
          state_d     = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        adr_d       = '0;
        dat_d       = '0;
        sel_d       = '0;
        we_d        = 1'b0;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = '0;
        rsp_err_d   = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      to_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      to_count_q  <= to_count_d;
    end
  end

  assign bus.cmd_ready_o    = cmd_ready;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_dat_o      = rsp_dat_q;
  assign bus.rsp_err_o      = rsp_err_q;
  assign bus.WBm_ADR_o      = adr_q;
  assign bus.WBm_DAT_o      = dat_q;
  assign bus.WBm_BYTE_STB_o = sel_q;
  assign bus.WBm_WE_o       = we_q;
  assign bus.WBm_CYC_o      = cyc_q;
  assign bus.WBm_STB_o      = cyc_q;
  assign bus.state_dbg      = state_q;
  assign to_count_o         = to_count_q;
endmodule

// File: tb/tb_al4s3b_wb_master.sv
// Directed bench for al4s3b_wb_master: the bench plays command source, response sink and bus slave.
module tb_al4s3b_wb_master;
  import al4s3b_wb_pkg::*;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [31:0] ERR_VAL = 32'hDEFFABAC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] to_count;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  al4s3b_wb_master_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  al4s3b_wb_master #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .TO_CNTR_WIDTH(5), .TO_CYCLES(TO), .ERR_RD_VALUE(ERR_VAL)
  ) dut (
    .WBs_CLK_i  (clk),
    .WBs_RST_i  (rst),
    .bus        (bus.master),
    .to_count_o (to_count)
  );

  // Driver: called at a negedge; presents the command for exactly one accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL issue_ready got=%b exp=1", bus.cmd_ready_o);
    end
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = we; bus.cmd_adr_i = adr;
    bus.cmd_dat_i = dat; bus.cmd_sel_i = sel;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  // Slave model: called at the negedge of the first STB cycle. ack_at=0 never acks.
  // Returns at the first negedge with STB low, counting STB cycles and bus stability.
  task automatic slave(input int ack_at, input logic [31:0] rdat, input logic we,
                       input logic [AW-1:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       output int stb_cnt, output bit stable);
    stb_cnt = 0; stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.WBm_STB_o !== 1'b1) break;
      stb_cnt++;
      if (bus.WBm_CYC_o !== 1'b1 || bus.WBm_WE_o !== we || bus.WBm_ADR_o !== adr ||
          bus.WBm_DAT_o !== dat || bus.WBm_BYTE_STB_o !== sel) stable = 1'b0;
      if (stb_cnt == ack_at) begin bus.WBm_ACK_i = 1'b1; bus.WBm_DAT_i = rdat; end
      @(negedge clk);
      bus.WBm_ACK_i = 1'b0; bus.WBm_DAT_i = 32'hFFFF_FFFF;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({bus.WBm_CYC_o, bus.WBm_STB_o, bus.WBm_WE_o} !== 3'b000) begin
      failures++; $display("FAIL reset_cyc_stb_we got=%b exp=000", {bus.WBm_CYC_o, bus.WBm_STB_o, bus.WBm_WE_o}); end
    checks++; if ({bus.WBm_ADR_o, bus.WBm_DAT_o, bus.WBm_BYTE_STB_o} !== '0) begin
      failures++; $display("FAIL reset_adr_dat_sel got=%h exp=0", {bus.WBm_ADR_o, bus.WBm_DAT_o, bus.WBm_BYTE_STB_o}); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== '0) begin
      failures++; $display("FAIL reset_rsp got=%h exp=0", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}); end
    checks++; if (to_count !== 8'd0) begin
      failures++; $display("FAIL reset_to_count got=%0d exp=0", to_count); end
    checks++; if (bus.cmd_ready_o !== 1'b1 || bus.state_dbg !== ST_IDLE) begin
      failures++; $display("FAIL reset_idle got=%b/%0d exp=1/0", bus.cmd_ready_o, bus.state_dbg); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int n; bit st;
    issue(1'b1, 17'h00100, 32'h12345678, 4'hF);
    slave(2, 32'h0, 1'b1, 17'h00100, 32'h12345678, 4'hF, n, st);
    checks++; if (n != 2) begin failures++; $display("FAIL write_stb_cycles got=%0d exp=2", n); end
    checks++; if (!st) begin failures++; $display("FAIL write_bus_stable got=0 exp=1"); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'h0}) begin
      failures++; $display("FAIL write_rsp got=%b/%b/%h exp=1/0/00000000", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o); end
    take_rsp();
    checks++; if (bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL write_release got=%b/%b exp=0/1", bus.rsp_valid_o, bus.cmd_ready_o); end
    checks++; if (bus.WBm_ADR_o !== 17'h00100 || bus.WBm_DAT_o !== 32'h12345678 || bus.WBm_WE_o !== 1'b1) begin
      failures++; $display("FAIL write_bus_hold got=%h/%h exp=00100/12345678", bus.WBm_ADR_o, bus.WBm_DAT_o); end
  endtask

  task automatic test_read_fast();
    int n; bit st;
    issue(1'b0, 17'h001FC, 32'h0, 4'hF);
    slave(1, 32'h00000100, 1'b0, 17'h001FC, 32'h0, 4'hF, n, st);
    checks++; if (n != 1 || !st) begin failures++; $display("FAIL read_fast_stb got=%0d/%0d exp=1/1", n, st); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'h00000100}) begin
      failures++; $display("FAIL read_fast_rsp got=%b/%b/%h exp=1/0/00000100", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o); end
    take_rsp();
  endtask

  task automatic test_timeout();
    int n; bit st;
    issue(1'b0, 17'h00040, 32'h0, 4'h3);
    slave(0, 32'h0, 1'b0, 17'h00040, 32'h0, 4'h3, n, st);
    checks++; if (n != TO || !st) begin failures++; $display("FAIL timeout_stb got=%0d/%0d exp=16/1", n, st); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b11, ERR_VAL}) begin
      failures++; $display("FAIL timeout_rsp got=%b/%b/%h exp=1/1/deffabac", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o); end
    checks++; if (to_count !== 8'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", to_count); end
    take_rsp();
  endtask

  task automatic test_ack_last();
    int n; bit st;
    issue(1'b0, 17'h00080, 32'h0, 4'hF);
    slave(TO, 32'hCAFEF00D, 1'b0, 17'h00080, 32'h0, 4'hF, n, st);
    checks++; if (n != TO) begin failures++; $display("FAIL ack_last_stb got=%0d exp=16", n); end
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'hCAFEF00D}) begin
      failures++; $display("FAIL ack_last_rsp got=%b/%b/%h exp=1/0/cafef00d", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o); end
    checks++; if (to_count !== 8'd1) begin failures++; $display("FAIL ack_last_count got=%0d exp=1", to_count); end
    take_rsp();
  endtask

  task automatic test_write_timeout();
    int n; bit st;
    issue(1'b1, 17'h1FFFC, 32'hA5A5_5A5A, 4'h1);
    slave(0, 32'h0, 1'b1, 17'h1FFFC, 32'hA5A5_5A5A, 4'h1, n, st);
    checks++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b11, 32'h0}) begin
      failures++; $display("FAIL wr_timeout_rsp got=%b/%b/%h exp=1/1/00000000", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o); end
    checks++; if (to_count !== 8'd2) begin failures++; $display("FAIL wr_timeout_count got=%0d exp=2", to_count); end
    take_rsp();
  endtask

  task automatic test_backpressure();
    int n; bit st; bit held = 1'b1;
    issue(1'b0, 17'h00010, 32'h0, 4'hF);
    slave(1, 32'h0BAD_BEEF, 1'b0, 17'h00010, 32'h0, 4'hF, n, st);
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b1; bus.cmd_adr_i = 17'h00020;
    bus.cmd_dat_i = 32'h0000_0042; bus.cmd_sel_i = 4'hC;
    repeat (5) begin
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h0BAD_BEEF || bus.rsp_err_o !== 1'b0 ||
          bus.cmd_ready_o !== 1'b0 || bus.WBm_CYC_o !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    checks++; if (!held) begin failures++; $display("FAIL bp_hold got=0 exp=1"); end
    take_rsp();
    checks++; if (bus.cmd_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0 || bus.WBm_CYC_o !== 1'b0) begin
      failures++; $display("FAIL bp_release got=%b/%b/%b exp=1/0/0", bus.cmd_ready_o, bus.rsp_valid_o, bus.WBm_CYC_o); end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    checks++; if (bus.WBm_CYC_o !== 1'b1 || bus.WBm_ADR_o !== 17'h00020 || bus.WBm_BYTE_STB_o !== 4'hC) begin
      failures++; $display("FAIL bp_next_accept got=%b/%h/%h exp=1/00020/c", bus.WBm_CYC_o, bus.WBm_ADR_o, bus.WBm_BYTE_STB_o); end
    slave(1, 32'h0, 1'b1, 17'h00020, 32'h0000_0042, 4'hC, n, st);
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h0) begin
      failures++; $display("FAIL bp_next_rsp got=%b/%h exp=1/00000000", bus.rsp_valid_o, bus.rsp_dat_o); end
    take_rsp();
  endtask

  task automatic test_ack_outside();
    bit quiet = 1'b1;
    bus.WBm_ACK_i = 1'b1; bus.WBm_DAT_i = 32'h1234_0000;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b0 || bus.state_dbg !== ST_IDLE || bus.WBm_CYC_o !== 1'b0) quiet = 1'b0;
    end
    bus.WBm_ACK_i = 1'b0;
    checks++; if (!quiet) begin failures++; $display("FAIL stray_ack got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    int n; bit st; bit quiet = 1'b1;
    issue(1'b0, 17'h00300, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus.WBm_CYC_o, bus.WBm_STB_o, bus.rsp_valid_o} !== 3'b000 || to_count !== 8'd0) begin
      failures++; $display("FAIL rst_mid_drop got=%b/%0d exp=000/0", {bus.WBm_CYC_o, bus.WBm_STB_o, bus.rsp_valid_o}, to_count); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b0 || bus.WBm_CYC_o !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL rst_mid_no_rsp got=0 exp=1"); end
    issue(1'b1, 17'h00304, 32'h7777_0001, 4'hF);
    slave(1, 32'h0, 1'b1, 17'h00304, 32'h7777_0001, 4'hF, n, st);
    checks++; if (n != 1 || !st || {bus.rsp_valid_o, bus.rsp_err_o} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_after got=%0d/%0d/%b exp=1/1/10", n, st, {bus.rsp_valid_o, bus.rsp_err_o}); end
    take_rsp();
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0;
    bus.cmd_dat_i = '0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b0;
    bus.WBm_ACK_i = 1'b0; bus.WBm_DAT_i = 32'hFFFF_FFFF;
    test_reset();
    test_write();
    test_read_fast();
    test_timeout();
    test_ack_last();
    test_write_timeout();
    test_backpressure();
    test_ack_outside();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
